// File: rtl/uart_arb_pkg.sv
// Shared definitions for the UART transmit arbiter.
//
// Contents:
//   arb_state_t  - four-state sequencing of one byte transfer
//   EOP_DEFAULT  - default end-of-packet byte (line feed)
//   sat_inc      - saturating 8-bit increment used by the burst counter
package uart_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        LOAD    = 2'd2,
        PRESENT = 2'd3
    } arb_state_t;

    localparam logic [7:0] EOP_DEFAULT = 8'h0A;

    // Counts up to limit and then sticks there, so a long burst never wraps
    // back to a small count and accidentally extends the grant.
    function automatic logic [7:0] sat_inc(input logic [7:0] value,
                                           input logic [7:0] limit);
        return (value >= limit) ? value : value + 8'd1;
    endfunction

endpackage

// File: rtl/rr_picker.sv
// Round-robin request picker.
//
// Searches the request vector starting one position after ptr and wrapping
// at NUM_SRC-1 back to 0; the first set request wins.
//
// Ports:
//   req    in  NUM_SRC  request vector, bit i set when source i wants service
//   ptr    in  IDX_W    index of the most recently granted source
//   index  out IDX_W    chosen source (0 when nothing is requested)
//   valid  out 1        high when at least one request is set
module rr_picker #(
    parameter int NUM_SRC = 4,
    parameter int IDX_W   = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [IDX_W-1:0]   index,
    output logic               valid
);

    logic [IDX_W-1:0] cand;

    // The last granted source is visited last (k = NUM_SRC), which is what
    // keeps a busy source from being picked twice in one rotation.
    always_comb begin
        index = '0;
        valid = 1'b0;
        cand  = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_SRC);
            if (!valid && req[cand]) begin
                index = cand;
                valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Arbiter that merges several byte FIFOs onto one UART transmitter.
//
// A source is granted round-robin and keeps the grant for a packet: bytes are
// fetched one at a time until the end-of-packet byte is sent, MAX_BURST bytes
// have gone out, or the source runs dry. No preemption while busy.
//
// Ports:
//   clk        in   1           rising-edge clock
//   rst        in   1           asynchronous active-low reset
//   src_dout   in   8*NUM_SRC   packed FIFO data, source i in [8i+7:8i]
//   src_empty  in   NUM_SRC     per-source FIFO empty flags
//   src_re     out  NUM_SRC     per-source read enable (one-hot or zero)
//   tx_din     out  8           byte offered to the transmitter
//   tx_empty   out  1           high when no byte is offered
//   tx_re      in   1           transmitter read strobe
//   grant_id   out  IDX_W       current or last granted source
//   busy       out  1           high while a grant is held
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter int         NUM_SRC   = 4,
    parameter int         MAX_BURST = 16,
    parameter logic [7:0] EOP_BYTE  = EOP_DEFAULT
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [8*NUM_SRC-1:0]       src_dout,
    input  logic [NUM_SRC-1:0]         src_empty,
    output logic [NUM_SRC-1:0]         src_re,
    output logic [7:0]                 tx_din,
    output logic                       tx_empty,
    input  logic                       tx_re,
    output logic [$clog2(NUM_SRC)-1:0] grant_id,
    output logic                       busy
);

    localparam int         IDX_W       = $clog2(NUM_SRC);
    localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

    arb_state_t       state, state_next;
    logic [IDX_W-1:0] grant_q, grant_next;
    logic [IDX_W-1:0] rr_ptr, rr_ptr_next;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_valid;
    logic [7:0]       hold_q, hold_next;
    logic [7:0]       count_q, count_next;
    logic [NUM_SRC-1:0] req;
    logic [7:0]       src_bytes [NUM_SRC];
    logic             release_now;

    assign req = ~src_empty;

    rr_picker #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req   (req),
        .ptr   (rr_ptr),
        .index (pick_idx),
        .valid (pick_valid)
    );

    // Unpack the source data bus so the granted byte can be selected by index.
    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            src_bytes[i] = src_dout[8*i +: 8];
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Datapath registers. The round-robin pointer resets to the last source
    // so that source 0 is searched first after reset, while grant_id reads 0.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant_q <= '0;
            rr_ptr  <= IDX_W'(NUM_SRC - 1);
            hold_q  <= 8'h00;
            count_q <= 8'h00;
        end else begin
            grant_q <= grant_next;
            rr_ptr  <= rr_ptr_next;
            hold_q  <= hold_next;
            count_q <= count_next;
        end
    end

    // The release test in PRESENT looks at src_empty after this byte's read
    // has already been applied, so "empty" really means nothing left to send.
    assign release_now = (hold_q == EOP_BYTE) || (count_q == BURST_LIMIT) ||
                         src_empty[grant_q];

    // Next-state and output decode.
    always_comb begin
        state_next  = state;
        grant_next  = grant_q;
        rr_ptr_next = rr_ptr;
        hold_next   = hold_q;
        count_next  = count_q;
        src_re      = '0;
        tx_empty    = 1'b1;
        busy        = (state != IDLE);

        case (state)
            IDLE: begin
                if (pick_valid) begin
                    grant_next  = pick_idx;
                    rr_ptr_next = pick_idx;
                    count_next  = 8'h00;
                    state_next  = FETCH;
                end
            end
            FETCH: begin
                src_re[grant_q] = 1'b1;
                state_next      = LOAD;
            end
            LOAD: begin
                hold_next  = src_bytes[grant_q];
                count_next = sat_inc(count_q, BURST_LIMIT);
                state_next = PRESENT;
            end
            PRESENT: begin
                tx_empty = 1'b0;
                if (tx_re) begin
                    state_next = release_now ? IDLE : FETCH;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign tx_din   = hold_q;
    assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter.
//
// Source FIFOs are modelled as byte queues with one cycle of read latency.
// A packet-level reference model replays the same preloaded bytes through the
// arbitration rules and produces the expected (source, byte, releases) stream.
module tb_uart_tx_arbiter;

    localparam int         NUM_SRC   = 4;
    localparam int         MAX_BURST = 4;
    localparam int         IDX_W     = $clog2(NUM_SRC);
    localparam logic [7:0] EOP       = 8'h0A;

    logic                   clk = 1'b0;
    logic                   rst = 1'b1;
    logic [8*NUM_SRC-1:0]   src_dout;
    logic [NUM_SRC-1:0]     src_empty;
    logic [NUM_SRC-1:0]     src_re;
    logic [7:0]             tx_din;
    logic                   tx_empty;
    logic                   tx_re = 1'b0;
    logic [IDX_W-1:0]       grant_id;
    logic                   busy;

    int total = 0;
    int bad   = 0;

    uart_tx_arbiter #(
        .NUM_SRC   (NUM_SRC),
        .MAX_BURST (MAX_BURST),
        .EOP_BYTE  (EOP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .src_dout  (src_dout),
        .src_empty (src_empty),
        .src_re    (src_re),
        .tx_din    (tx_din),
        .tx_empty  (tx_empty),
        .tx_re     (tx_re),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Source FIFO model: a read pops the head into the output register, which
    // the arbiter sees on the following cycle; empty reflects the post-pop size.
    logic [7:0]         fifo_q [NUM_SRC][$];
    logic [7:0]         dout_r [NUM_SRC] = '{default: 8'h00};
    logic [NUM_SRC-1:0] empty_r = '1;

    always @(posedge clk) begin
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_re[i] && fifo_q[i].size() > 0) dout_r[i] <= fifo_q[i].pop_front();
            empty_r[i] <= (fifo_q[i].size() == 0);
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) src_dout[8*i +: 8] = dout_r[i];
    end
    assign src_empty = empty_r;

    // Reference model state.
    logic [7:0] mq [NUM_SRC][$];
    logic [7:0] exp_byte [$];
    int         exp_src  [$];
    bit         exp_rel  [$];
    int         model_ptr = NUM_SRC - 1;

    task automatic push_byte(input int s, input logic [7:0] b);
        fifo_q[s].push_back(b);
        mq[s].push_back(b);
    endtask

    task automatic load_str(input int s, input string str);
        for (int i = 0; i < str.len(); i++) push_byte(s, str[i]);
    endtask

    task automatic clear_all();
        for (int i = 0; i < NUM_SRC; i++) begin
            fifo_q[i].delete();
            mq[i].delete();
        end
        exp_byte.delete();
        exp_src.delete();
        exp_rel.delete();
    endtask

    // Whole-packet view: pick the next pending source after the last one,
    // then drain it until EOP, the burst limit, or its queue runs out.
    task automatic build_expect();
        int c, n;
        bit done;
        logic [7:0] b;
        forever begin
            c = -1;
            for (int k = 1; k <= NUM_SRC; k++) begin
                if (c < 0 && mq[(model_ptr + k) % NUM_SRC].size() > 0) c = (model_ptr + k) % NUM_SRC;
            end
            if (c < 0) break;
            model_ptr = c;
            n = 0;
            done = 1'b0;
            while (!done) begin
                b = mq[c].pop_front();
                n++;
                done = (b == EOP) || (n == MAX_BURST) || (mq[c].size() == 0);
                exp_byte.push_back(b);
                exp_src.push_back(c);
                exp_rel.push_back(done);
            end
        end
    endtask

    // Acts as the transmitter: reads offered bytes with probability read_pct,
    // sometimes strobes tx_re while nothing is offered, and checks each byte,
    // its source, the hold of tx_din after the read, and busy after the read.
    task automatic run_until_drained(input int budget, input int read_pct);
        int         cycles = 0;
        bit         pend = 1'b0;
        bit         pend_busy = 1'b0;
        logic [7:0] last = 8'h00;
        while (exp_byte.size() > 0 && cycles < budget) begin
            @(negedge clk);
            cycles++;
            total++;
            if ($countones(src_re) > 1) begin
                bad++;
                $display("[TB] FAIL src_re_onehot got=%b need at most one bit", src_re);
            end
            if (pend) begin
                total++;
                if (busy !== pend_busy) begin
                    bad++;
                    $display("[TB] FAIL busy_after_read got=%b need=%b", busy, pend_busy);
                end
                total++;
                if (tx_din !== last) begin
                    bad++;
                    $display("[TB] FAIL tx_din_hold got=%h need=%h", tx_din, last);
                end
                pend = 1'b0;
            end
            tx_re = 1'b0;
            if (!tx_empty && $urandom_range(99) < read_pct) begin
                total++;
                if (tx_din !== exp_byte[0]) begin
                    bad++;
                    $display("[TB] FAIL tx_byte got=%h need=%h", tx_din, exp_byte[0]);
                end
                total++;
                if (int'(grant_id) !== exp_src[0]) begin
                    bad++;
                    $display("[TB] FAIL grant_id got=%0d need=%0d", grant_id, exp_src[0]);
                end
                last      = exp_byte.pop_front();
                pend_busy = !exp_rel.pop_front();
                void'(exp_src.pop_front());
                pend      = 1'b1;
                tx_re     = 1'b1;
            end else if (tx_empty && $urandom_range(3) == 0) begin
                tx_re = 1'b1;
            end
        end
        @(negedge clk);
        tx_re = 1'b0;
        if (pend) begin
            total++;
            if (busy !== pend_busy) begin
                bad++;
                $display("[TB] FAIL busy_after_read got=%b need=%b", busy, pend_busy);
            end
            total++;
            if (tx_din !== last) begin
                bad++;
                $display("[TB] FAIL tx_din_hold got=%h need=%h", tx_din, last);
            end
        end
        total++;
        if (exp_byte.size() != 0) begin
            bad++;
            $display("[TB] FAIL drain_timeout got=%0d bytes left need=0", exp_byte.size());
            clear_all();
        end
    endtask

    task automatic check_reset_values(input string tag);
        total++;
        if (src_re !== '0 || tx_empty !== 1'b1 || tx_din !== 8'h00 ||
            grant_id !== '0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL %s got src_re=%b tx_empty=%b tx_din=%h grant=%0d busy=%b need 0/1/00/0/0",
                     tag, src_re, tx_empty, tx_din, grant_id, busy);
        end
    endtask

    task automatic test_reset();
        #2 rst = 1'b0;
        #10;
        check_reset_values("reset_values");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_reset_values("idle_after_reset");
    endtask

    task automatic test_contention();
        @(negedge clk);
        load_str(0, "A\n");
        load_str(2, "B\n");
        build_expect();
        run_until_drained(200, 100);
    endtask

    task automatic test_single();
        @(negedge clk);
        load_str(1, "HI\n");
        build_expect();
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            total++;
            if (tx_empty !== (k < 4)) begin
                bad++;
                $display("[TB] FAIL latency_cycle%0d tx_empty got=%b need=%b", k, tx_empty, k < 4);
            end
        end
        run_until_drained(200, 100);
        total++;
        if (grant_id !== IDX_W'(1) || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_end got grant=%0d busy=%b need grant=1 busy=0", grant_id, busy);
        end
    endtask

    task automatic test_drain();
        @(negedge clk);
        load_str(0, "ab");
        load_str(1, "c\n");
        build_expect();
        run_until_drained(200, 80);
    endtask

    task automatic test_burst();
        @(negedge clk);
        load_str(3, "abcdef");
        build_expect();
        run_until_drained(300, 100);
    endtask

    task automatic test_backpressure();
        int wait_cnt = 0;
        @(negedge clk);
        load_str(2, "xy\n");
        build_expect();
        while (tx_empty && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (tx_empty) begin
            bad++;
            $display("[TB] FAIL backpressure_offer got tx_empty=1 need 0");
        end
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            total++;
            if (tx_din !== exp_byte[0] || src_re !== '0 || tx_empty !== 1'b0) begin
                bad++;
                $display("[TB] FAIL backpressure_hold got din=%h re=%b empty=%b need din=%h re=0 empty=0",
                         tx_din, src_re, tx_empty, exp_byte[0]);
            end
        end
        run_until_drained(200, 100);
    endtask

    task automatic test_random();
        logic [NUM_SRC-1:0] mask;
        int len;
        for (int it = 0; it < 20; it++) begin
            @(negedge clk);
            mask = NUM_SRC'($urandom_range(1, (1 << NUM_SRC) - 1));
            for (int s = 0; s < NUM_SRC; s++) begin
                if (mask[s]) begin
                    len = $urandom_range(1, 8);
                    for (int j = 0; j < len; j++)
                        push_byte(s, ($urandom_range(9) == 0) ? EOP : 8'($urandom_range(255)));
                end
            end
            build_expect();
            run_until_drained(2000, $urandom_range(30, 100));
        end
    endtask

    task automatic test_reset_in_load();
        int wait_cnt = 0;
        @(negedge clk);
        load_str(2, "Q\n");
        while (src_re == '0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        total++;
        if (src_re == '0) begin
            bad++;
            $display("[TB] FAIL fetch_before_reset got src_re=0 need a read");
        end
        @(posedge clk);
        #1 rst = 1'b0;
        #1 check_reset_values("reset_in_load");
        clear_all();
        model_ptr = NUM_SRC - 1;
        load_str(0, "S\n");
        load_str(1, "T\n");
        build_expect();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            total++;
            if (src_re !== '0) begin
                bad++;
                $display("[TB] FAIL re_during_reset got=%b need=0", src_re);
            end
        end
        rst = 1'b1;
        run_until_drained(200, 100);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL global_timeout got=running need=finished");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        test_reset();
        test_contention();
        test_single();
        test_drain();
        test_burst();
        test_backpressure();
        test_random();
        test_reset_in_load();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_SRC, default 4: number of requesting byte FIFOs (2..8).
REQ-002 SHALL have parameter MAX_BURST, default 16: maximum bytes per grant (1..255).
REQ-003 SHALL have parameter EOP_BYTE, default 8'h0A: end-of-packet byte that releases a grant.
REQ-004 SHALL have port clk  input  1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst  input  1: asynchronous, active-low reset.
REQ-006 SHALL have port src_dout  input  8*NUM_SRC: packed source FIFO data; source i in bits [8i+7:8i].
REQ-007 SHALL have port src_empty  input  NUM_SRC: per-source FIFO empty flag.
REQ-008 SHALL have port src_re  output  NUM_SRC: per-source read enable; at most one bit high per cycle.
REQ-009 SHALL have port tx_din  output  8: byte offered to the UART transmitter.
REQ-010 SHALL have port tx_empty  output  1: high when no byte is offered.
REQ-011 SHALL have port tx_re  input  1: transmitter read strobe.
REQ-012 SHALL have port grant_id  output  $clog2(NUM_SRC): index of the current or last granted source.
REQ-013 SHALL have port busy  output  1: high while a grant is held.

Function
REQ-014 SHALL treat source FIFOs as read-latency-1: src_dout of source i is valid in the cycle after src_re[i].
REQ-015 SHALL implement states IDLE, FETCH, LOAD, PRESENT.
REQ-016 In IDLE, if any src_empty bit is low, SHALL pick the first non-empty source searching round-robin from last grant+1 (mod NUM_SRC), latch grant_id, clear the burst counter, set busy, and go to FETCH.
REQ-017 In FETCH, SHALL assert src_re[grant_id] for exactly one cycle and go to LOAD.
REQ-018 In LOAD, SHALL capture src_dout[grant_id] into the hold register driving tx_din, increment the burst counter, and go to PRESENT.
REQ-019 In PRESENT, SHALL drive tx_empty low; otherwise tx_empty SHALL be high.
REQ-020 In PRESENT with tx_re high, SHALL release the grant (busy low, go to IDLE) if the byte equals EOP_BYTE, the burst counter equals MAX_BURST, or src_empty[grant_id] is high.
REQ-021 In PRESENT with tx_re high and no release condition, SHALL return to FETCH on the same source.
REQ-022 SHALL keep tx_din stable from LOAD until the next LOAD, so the byte stays valid in the cycle after tx_re.
REQ-023 SHALL ignore tx_re outside PRESENT.
REQ-024 SHALL ignore changes of non-granted src_empty bits while busy; no preemption.
REQ-025 Latency SHALL be: non-empty source seen in IDLE, then tx_empty low 3 cycles later.
REQ-026 Burst counter SHALL be 8 bits wide, saturate at MAX_BURST, and never wrap.
REQ-027 Round-robin pointer SHALL wrap from NUM_SRC-1 to 0.
REQ-028 Each source SHALL be granted at most once per rotation while others are pending; starvation is forbidden.

Reset
REQ-029 On rst low, SHALL immediately drive: state IDLE, src_re 0, tx_empty 1, tx_din 8'h00, grant_id 0, busy 0, counter 0, round-robin pointer NUM_SRC-1 (source 0 is first priority).
REQ-030 Reset mid-burst SHALL drop the held byte and SHALL NOT assert any src_re until after rst rises.

Structure
REQ-031 SHALL place the state enum and EOP default constant in shared package uart_arb_pkg.
REQ-032 SHALL implement round-robin selection in sub-module rr_picker (inputs: request vector, pointer; outputs: index, valid).

Verification
REQ-033 Single source: source 1 holds "HI\n" and others are empty -> tx sees 48,49,0A; grant_id 1; busy falls after 0A is read.
REQ-034 Contention: sources 0 and 2 each hold "A\n" and "B\n" -> order 41,0A,42,0A; grant 0 then 2.
REQ-035 Burst limit, MAX_BURST=4: source 3 holds 6 bytes with no 0A -> 4 bytes, release, re-grant 3 (the only requester), remaining 2 bytes.
REQ-036 Source drains mid-packet: source 0 holds 2 bytes and no EOP -> release after byte 2; source 1 is granted next.
REQ-037 Backpressure: tx_re held low 50 cycles in PRESENT -> tx_din stable, no src_re pulse, no byte lost.
REQ-038 Reset in LOAD -> outputs reach reset values asynchronously; after release, arbitration restarts with source 0 first.
